// File: rtl/pc_redirect_ctrl_if.sv
// Bundle between the redirect sources / PC generator and pc_redirect_ctrl.
// The controller uses the slave view; the environment driving it uses master.
interface pc_redirect_ctrl_if #(
    parameter int CAUSE_W = 5
);
    logic               fetch_stall;
    logic               load_use_stall;
    logic               br_taken;
    logic [31:0]        br_target;
    logic               jal_valid;
    logic [31:0]        jal_target;
    logic               trap_req;
    logic [31:0]        trap_pc;
    logic [CAUSE_W-1:0] trap_cause;
    logic               irq_req;
    logic               irq_en;
    logic [31:0]        irq_pc;
    logic               mret_valid;
    logic [31:0]        mtvec;
    logic               pc_stall;
    logic               pc_flush;
    logic [31:0]        pc_new;
    logic               flush_if_id;
    logic               flush_id_ex;
    logic [31:0]        mepc;
    logic [CAUSE_W:0]   mcause;
    logic               trap_busy;

    modport slave (
        input  fetch_stall, load_use_stall, br_taken, br_target, jal_valid, jal_target,
               trap_req, trap_pc, trap_cause, irq_req, irq_en, irq_pc, mret_valid, mtvec,
        output pc_stall, pc_flush, pc_new, flush_if_id, flush_id_ex, mepc, mcause, trap_busy
    );

    modport master (
        output fetch_stall, load_use_stall, br_taken, br_target, jal_valid, jal_target,
               trap_req, trap_pc, trap_cause, irq_req, irq_en, irq_pc, mret_valid, mtvec,
        input  pc_stall, pc_flush, pc_new, flush_if_id, flush_id_ex, mepc, mcause, trap_busy
    );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Control-flow controller: arbitrates branch/jal/trap/mret redirects into a single
// pending redirect held until the PC generator is unstalled, plus trap drain FSM.
module pc_redirect_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int CAUSE_W      = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    pc_redirect_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DRAIN, VECTOR} state_t;

    localparam logic [1:0] CLS_JAL  = 2'd1;
    localparam logic [1:0] CLS_BR   = 2'd2;
    localparam logic [1:0] CLS_TRAP = 2'd3;
    localparam logic [3:0] CNT_INIT = 4'(DRAIN_CYCLES - 1);

    function automatic logic [31:0] align(input logic [31:0] a);
        return a & ~32'd3;
    endfunction

    state_t             state_q;
    logic               pend_valid_q;
    logic [31:0]        pend_pc_q;
    logic [1:0]         pend_cls_q;
    logic [31:0]        mepc_q;
    logic [CAUSE_W:0]   mcause_q;
    logic [3:0]         cnt_q;

    logic               in_idle, in_drain, stall, consume;
    logic               trap_take, mret_take;
    logic               ev_valid, ev_ok;
    logic [1:0]         ev_cls;
    logic [31:0]        ev_pc;
    logic [31:0]        cap_mepc_d;
    logic [CAUSE_W:0]   cap_mcause_d;

    assign in_idle   = (state_q == IDLE);
    assign in_drain  = (state_q == DRAIN);
    assign stall     = bus.fetch_stall | bus.load_use_stall | in_drain;
    // The PC generator ignores flush while stalled, so only an unstalled cycle consumes.
    assign consume   = pend_valid_q & ~stall;
    assign trap_take = in_idle & (bus.trap_req | (bus.irq_req & bus.irq_en));
    assign mret_take = in_idle & bus.mret_valid & ~trap_take;

    always_comb begin
        cap_mepc_d   = bus.irq_pc;
        cap_mcause_d = {1'b1, {CAUSE_W{1'b0}}};
        if (bus.trap_req) begin
            cap_mepc_d   = bus.trap_pc;
            cap_mcause_d = {1'b0, bus.trap_cause};
        end
    end

    always_comb begin
        ev_valid = 1'b0;
        ev_cls   = 2'd0;
        ev_pc    = 32'd0;
        if (mret_take) begin
            ev_valid = 1'b1;
            ev_cls   = CLS_TRAP;
            ev_pc    = mepc_q;
        end else if (in_idle && !trap_take && bus.br_taken) begin
            ev_valid = 1'b1;
            ev_cls   = CLS_BR;
            ev_pc    = bus.br_target;
        end else if (in_idle && !trap_take && bus.jal_valid) begin
            ev_valid = 1'b1;
            ev_cls   = CLS_JAL;
            ev_pc    = bus.jal_target;
        end
    end

    // A slot being consumed this edge is free for any class.
    assign ev_ok = ev_valid & (~pend_valid_q | consume | (ev_cls >= pend_cls_q));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= 32'd0;
            pend_cls_q   <= 2'd0;
            mepc_q       <= 32'd0;
            mcause_q     <= '0;
            cnt_q        <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (trap_take) begin
                        state_q      <= DRAIN;
                        cnt_q        <= CNT_INIT;
                        pend_valid_q <= 1'b0;
                        mepc_q       <= cap_mepc_d;
                        mcause_q     <= cap_mcause_d;
                    end else if (ev_ok) begin
                        pend_valid_q <= 1'b1;
                        pend_pc_q    <= align(ev_pc);
                        pend_cls_q   <= ev_cls;
                    end else if (consume) begin
                        pend_valid_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (cnt_q == 4'd0) begin
                        state_q      <= VECTOR;
                        pend_valid_q <= 1'b1;
                        pend_pc_q    <= align(bus.mtvec);
                        pend_cls_q   <= CLS_TRAP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                VECTOR: begin
                    if (bus.trap_req) begin
                        state_q      <= DRAIN;
                        cnt_q        <= CNT_INIT;
                        pend_valid_q <= 1'b0;
                        mepc_q       <= cap_mepc_d;
                        mcause_q     <= cap_mcause_d;
                    end else if (consume) begin
                        state_q      <= IDLE;
                        pend_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Combinational strobes are gated so every output reads 0 while in reset.
    assign bus.pc_stall    = reset_n & stall;
    assign bus.flush_if_id = reset_n & (in_drain | bus.br_taken | bus.jal_valid | mret_take);
    assign bus.flush_id_ex = reset_n & (in_drain | bus.br_taken | mret_take);
    assign bus.pc_flush    = pend_valid_q;
    assign bus.pc_new      = pend_pc_q;
    assign bus.mepc        = mepc_q;
    assign bus.mcause      = mcause_q;
    assign bus.trap_busy   = ~in_idle;
endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Control-flow controller that drives the stall/flush/new_pc inputs of the PC generator.
- Arbitrates redirect sources: EX branch, ID jump, trap/interrupt entry and mret.
- Combines stall sources and emits pipeline-register flush strobes.
- Holds a redirect pending until the PC generator can accept it, because the PC generator ignores flush while stalled.

Parameters:
- DRAIN_CYCLES, 2, cycles of forced stall between trap acceptance and the trap-vector redirect; legal range 1..15.
- CAUSE_W, 5, width of the mcause field.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- fetch_stall  in  1  instruction memory not ready.
- load_use_stall  in  1  hazard unit load-use stall.
- br_taken  in  1  EX-stage branch or jalr resolved taken.
- br_target  in  32  EX redirect target.
- jal_valid  in  1  ID-stage jal decoded.
- jal_target  in  32  ID redirect target.
- trap_req  in  1  synchronous exception from EX.
- trap_pc  in  32  PC of the faulting instruction.
- trap_cause  in  CAUSE_W  exception code.
- irq_req  in  1  level interrupt request.
- irq_en  in  1  global interrupt enable.
- irq_pc  in  32  PC to resume after the interrupt.
- mret_valid  in  1  EX-stage mret.
- mtvec  in  32  trap vector base.
- pc_stall  out  1  to PC generator stall.
- pc_flush  out  1  to PC generator flush.
- pc_new  out  32  to PC generator new_pc.
- flush_if_id  out  1  clear IF/ID register.
- flush_id_ex  out  1  clear ID/EX register.
- mepc  out  32  saved exception PC.
- mcause  out  CAUSE_W+1  bit[CAUSE_W] = interrupt flag; low bits = code.
- trap_busy  out  1  trap FSM not IDLE.

Behaviour:
- Reset (reset_n=0, async, any state): state=IDLE, pend_valid=0, pend_pc=0, mepc=0, mcause=0, drain counter=0.
  - All outputs 0 during reset.
  - Reset asserted mid-drain or with a redirect pending discards the redirect.
- Stall output: pc_stall = fetch_stall | load_use_stall | (state==DRAIN). This is combinational.
- Redirect outputs: pc_flush = pend_valid; pc_new = pend_pc. Both are registered.
- Redirect latency: an event sampled at edge N produces pc_flush=1 with the target during cycle N+1.
- Consume: pend_valid clears at the edge where pend_valid & !pc_stall. The PC generator loads pc_new at the same edge.
- Pending hold: while pc_stall=1, pend_valid and pend_pc hold. The redirect is never lost.
- Redirect class priority: TRAP/MRET (3) > branch (2) > jal (1).
  - A new event overwrites the pending redirect if its class >= the pending class.
  - A lower-class event is dropped.
  - Same-cycle events resolve by class; jal_valid is ignored when br_taken=1.
- Target alignment: every loaded pend_pc has bits [1:0] forced to 00.
- Flush strobes (combinational):
  - br_taken=1 -> flush_if_id=1 and flush_id_ex=1.
  - jal_valid=1 (and not br_taken) -> flush_if_id=1.
  - state==DRAIN -> both flushes=1.
- Trap FSM states: IDLE, DRAIN, VECTOR.
  - IDLE -> DRAIN on trap_req, or on irq_req & irq_en.
    - trap_req wins over irq_req in the same cycle.
    - Trap capture: mepc=trap_pc; mcause={0,trap_cause}.
    - Interrupt capture: mepc=irq_pc; mcause={1,0...0}.
    - Counter loads DRAIN_CYCLES-1.
    - Any pending redirect is discarded.
    - br_taken/jal_valid in the entry cycle are dropped.
  - DRAIN: counter decrements each cycle.
    - br_taken, jal_valid, mret_valid, trap_req and irq_req are ignored.
    - When counter==0: pend_pc={mtvec[31:2],00}, pend_valid=1, state -> VECTOR.
  - VECTOR: wait until the redirect is consumed, then -> IDLE.
    - Only another trap_req may overwrite (class 3); it re-enters DRAIN with a fresh capture.
- mret_valid in IDLE (no trap_req): loads pend_pc={mepc[31:2],00} at class 3; state stays IDLE; asserts both flushes.
- trap_busy = (state != IDLE).

Test Plan:
1. Plain branch: br_taken=1, br_target=0x100 at cycle 5, no stalls -> cycle 6 pc_flush=1, pc_new=0x100; cycle 7 pc_flush=0; flush_if_id=flush_id_ex=1 in cycle 5 only.
2. Redirect under stall: br_target=0x200 at cycle 5, fetch_stall high cycles 6-9 -> pc_flush=1, pc_new=0x200, pc_stall=1 through cycle 9; pend_valid clears at the end of the first unstalled cycle 10.
3. Priority: br_taken (0x300) and jal_valid (0x400) same cycle -> pc_new=0x300. Then jal 0x500 while the 0x300 branch is pending under stall -> pc_new stays 0x300.
4. Trap entry, DRAIN_CYCLES=2, mtvec=0x80000001: trap_req, trap_pc=0x44, cause=2 -> pc_stall=1 for 2 cycles; mepc=0x44; mcause=0x02; pc_new=0x80000000; trap_busy returns to 0 after consume.
5. Interrupt then mret: irq_req=irq_en=1, irq_pc=0x60 -> mcause=0x20, mepc=0x60. Later mret_valid -> pc_new=0x60 with both flushes.
6. Reset mid-drain: reset_n low during DRAIN -> all outputs 0 immediately. After release, trap_busy=0, pc_flush=0, and no vector redirect occurs.
